// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared definitions for the instruction fetch unit.
//   - PC-select encodings (shared with the decoder, values must not change)
//   - fetch FSM state encoding
//   - default reset PC
package ifu_fetch_pkg;

    localparam logic [2:0] NPC_ADD4   = 3'd0;
    localparam logic [2:0] NPC_J      = 3'd1;
    localparam logic [2:0] NPC_JR     = 3'd2;
    localparam logic [2:0] NPC_BRANCH = 3'd3;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/ifu_fetch_npc.sv
// npc_calc: combinational next-PC selection.
//   instr_pc  in  32  PC of the instruction in decode
//   target    in  26  instr[25:0]; jump index, low 16 bits are the branch offset
//   pcsrc     in  3   PC select from decoder
//   npcsrc    in  1   1 = jump-immediate, 0 = branch
//   br_taken  in  1   branch condition
//   rs_val    in  32  register target for jr/jalr
//   npc       out 32  next PC
//   pc_plus4  out 32  instr_pc + 4
module npc_calc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] instr_pc,
    input  logic [25:0] target,
    input  logic [2:0]  pcsrc,
    input  logic        npcsrc,
    input  logic        br_taken,
    input  logic [31:0] rs_val,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4
);

    logic [31:0] br_off;

    assign pc_plus4 = instr_pc + 32'd4;
    // sign-extended word offset, already shifted to a byte offset
    assign br_off   = {{14{target[15]}}, target[15:0], 2'b00};

    // A pcsrc/npcsrc pair that disagrees falls back to sequential fetch.
    always_comb begin
        npc = pc_plus4;
        case (pcsrc)
            NPC_J:      if (npcsrc) npc = {pc_plus4[31:28], target, 2'b00};
            NPC_BRANCH: if (!npcsrc && br_taken) npc = pc_plus4 + br_off;
            NPC_JR:     npc = rs_val;
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-issue instruction fetch unit, one memory request in flight.
//   clk, reset                      clock, synchronous active-high reset
//   imem_req/addr/gnt               request channel to instruction memory
//   imem_rvalid/rdata               response channel from instruction memory
//   instr/instr_pc/instr_valid      held instruction presented to decode
//   id_ready                        decode consumes instr
//   pcsrc/npcsrc/br_taken/rs_val    next-PC controls, sampled at the handshake
//   pc_plus4                        instr_pc + 4 for link registers
//   addr_err                        sticky misaligned-target error
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              id_ready,
    input  logic [2:0]        pcsrc,
    input  logic              npcsrc,
    input  logic              br_taken,
    input  logic [31:0]       rs_val,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              addr_err
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;

    npc_calc u_npc (
        .instr_pc (instr_pc),
        .target   (instr[25:0]),
        .pcsrc    (pcsrc),
        .npcsrc   (npcsrc),
        .br_taken (br_taken),
        .rs_val   (rs_val),
        .npc      (npc),
        .pc_plus4 (pc_plus4)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            case (state)
                // Coming out of reset the request is still low, so the first
                // FETCH cycle just raises it; a grant seen without a request
                // is not a handshake.
                ST_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                // instr_valid is always 1 here, so id_ready is only honoured
                // while an instruction is actually presented.
                ST_HOLD: begin
                    if (id_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= npc;
                        if (npc[1:0] != 2'b00) begin
                            addr_err <= 1'b1;
                            state    <= ST_HALT;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: ;
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed stimulus with a scoreboard. Stimulus pushes the
// expected fetch address and expected decode-side instruction; a monitor
// pops and compares on every memory grant and every decode handshake.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        id_ready;
    logic [2:0]  pcsrc;
    logic        npcsrc;
    logic        br_taken;
    logic [31:0] rs_val;
    logic [31:0] pc_plus4;
    logic        addr_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] p4;
    } exp_t;

    logic [31:0] addr_q[$];
    exp_t        instr_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_req  = 0;

    ifu_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .pcsrc       (pcsrc),
        .npcsrc      (npcsrc),
        .br_taken    (br_taken),
        .rs_val      (rs_val),
        .pc_plus4    (pc_plus4),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; outputs sampled on the falling edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_gnt) begin
                n_req++;
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, addr_q.pop_front());
                end
            end
            if (instr_valid && id_ready) begin
                if (instr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got %h expected none", instr);
                end else begin
                    exp_t e;
                    e = instr_q.pop_front();
                    chk("instr", instr, e.instr);
                    chk("instr_pc", instr_pc, e.pc);
                    chk("pc_plus4", pc_plus4, e.p4);
                end
            end
        end
    end

    // One fetch/decode transaction. gd: cycles gnt is withheld while req is high,
    // rd: cycles from grant to rvalid, yd: cycles decode stalls.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] w,
                             input int gd, input int rd, input int yd,
                             input logic [2:0] ps, input logic ns, input logic bt,
                             input logic [31:0] rs);
        exp_t e;
        int   n;
        e.instr = w;
        e.pc    = a;
        e.p4    = a + 32'd4;
        addr_q.push_back(a);
        instr_q.push_back(e);
        imem_gnt = (gd == 0);
        n = 0;
        @(negedge clk);
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no request expected addr %h", a);
            return;
        end
        for (int i = 1; i < gd; i++) begin
            step;
            @(negedge clk);
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_stable", imem_addr, a);
        end
        if (gd != 0) begin
            step;
            imem_gnt = 1'b1;
            @(negedge clk);
        end
        step;
        imem_gnt = 1'b0;
        for (int i = 1; i < rd; i++) begin
            imem_rvalid = 1'b0;
            id_ready    = 1'b1;   // must be ignored while nothing is presented
            @(negedge clk);
            chk("req_low_wait", 32'(imem_req), 32'd0);
            chk("valid_low_wait", 32'(instr_valid), 32'd0);
            step;
        end
        id_ready    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        step;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pcsrc       = ps;
        npcsrc      = ns;
        br_taken    = bt;
        rs_val      = rs;
        for (int i = 0; i < yd; i++) begin
            @(negedge clk);
            chk("valid_hold", 32'(instr_valid), 32'd1);
            chk("instr_stable", instr, w);
            step;
        end
        id_ready = 1'b1;
        @(negedge clk);
        step;
        // junk controls outside the handshake must not affect the next PC
        id_ready = 1'b0;
        pcsrc    = NPC_JR;
        npcsrc   = 1'b1;
        br_taken = 1'b1;
        rs_val   = 32'h0000_0001;
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        id_ready    = 1'b0;
        pcsrc       = NPC_ADD4;
        npcsrc      = 1'b0;
        br_taken    = 1'b0;
        rs_val      = 32'h0;
        repeat (2) step;
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        step;
        reset = 1'b0;

        // sequential
        fetch_one(32'h0000_3000, 32'h3401_0005, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        fetch_one(32'h0000_3004, 32'h3401_0005, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        fetch_one(32'h0000_3008, 32'h3401_0005, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        fetch_one(32'h0000_300C, 32'h3401_0005, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        // taken branch back by 3 words: 3014 - 12 = 3008
        fetch_one(32'h0000_3010, 32'h1000_FFFD, 0, 1, 0, NPC_BRANCH, 1'b0, 1'b1, 32'h0);
        fetch_one(32'h0000_3008, 32'h3401_0005, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        fetch_one(32'h0000_300C, 32'h3401_0005, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        // not taken
        fetch_one(32'h0000_3010, 32'h1000_FFFD, 0, 1, 0, NPC_BRANCH, 1'b0, 1'b0, 32'h0);
        // J with npcsrc=0 is inconsistent: sequential
        fetch_one(32'h0000_3014, 32'h0C00_0C00, 0, 1, 0, NPC_J, 1'b0, 1'b0, 32'h0);
        // undefined pcsrc: sequential
        fetch_one(32'h0000_3018, 32'h3401_0005, 0, 1, 0, 3'd5, 1'b0, 1'b0, 32'h0);
        // BRANCH with npcsrc=1 is inconsistent: sequential even if taken
        fetch_one(32'h0000_301C, 32'h1000_FFFD, 0, 1, 0, NPC_BRANCH, 1'b1, 1'b1, 32'h0);
        // jump index 0xC00 -> 0x3000
        fetch_one(32'h0000_3020, 32'h0C00_0C00, 0, 1, 0, NPC_J, 1'b1, 1'b0, 32'h0);
        // jump index 0xC10 -> 0x3040
        fetch_one(32'h0000_3000, 32'h0C00_0C10, 0, 1, 0, NPC_J, 1'b1, 1'b0, 32'h0);
        // variable latency and decode stall
        fetch_one(32'h0000_3040, 32'h3401_0005, 3, 4, 5, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        // jr to the top word, then sequential wrap to 0
        fetch_one(32'h0000_3044, 32'h0000_0008, 0, 1, 0, NPC_JR, 1'b0, 1'b0, 32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 32'h3401_0005, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);
        // misaligned jr target halts the unit
        fetch_one(32'h0000_0000, 32'h0000_0008, 0, 1, 0, NPC_JR, 1'b0, 1'b0, 32'h0000_3002);

        imem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("halt_err", 32'(addr_err), 32'd1);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(instr_valid), 32'd0);
            step;
        end
        imem_gnt = 1'b0;
        chk("req_count_halt", 32'(n_req), 32'd17);

        // reset clears the error
        reset = 1'b1;
        step;
        reset = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(addr_err), 32'd0);
        step;

        // reset while a request is outstanding; stale response afterwards
        addr_q.push_back(32'h0000_3000);
        imem_gnt = 1'b1;
        n = 0;
        @(negedge clk);
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midwait_req_seen", 32'(imem_req), 32'd1);
        step;
        imem_gnt = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("midwait_in_wait", 32'(imem_req), 32'd0);
        step;
        reset = 1'b0;
        @(negedge clk);
        chk("midwait_rst_valid", 32'(instr_valid), 32'd0);
        step;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stale_req_up", 32'(imem_req), 32'd1);
        step;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        @(negedge clk);
        chk("stale_ignored", 32'(instr_valid), 32'd0);
        step;
        fetch_one(32'h0000_3000, 32'h2402_0007, 0, 1, 0, NPC_ADD4, 1'b0, 1'b0, 32'h0);

        n = 0;
        @(negedge clk);
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("final_addr", imem_addr, 32'h0000_3004);
        chk("req_count_final", 32'(n_req), 32'd19);
        chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
        chk("instr_q_empty", 32'(instr_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
